// File: rtl/mod_pkg.sv
// Shared encodings and helpers for the symbol modulator: mode codes, symbol
// register layout, QPSK Gray phase table and the DAC midscale constant.
package mod_pkg;

    typedef enum logic [1:0] {
        MODE_ASK  = 2'b00,
        MODE_BPSK = 2'b01,
        MODE_QPSK = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // b_i is the first bit popped for a symbol, b_q the second (QPSK only).
    typedef struct packed {
        logic idle;
        logic b_i;
        logic b_q;
    } sym_t;

    localparam sym_t SYM_IDLE = 3'b100;

    // Gray-coded QPSK dibit to phase step k (units of 45 degrees).
    function automatic logic [2:0] qpsk_k(input logic [1:0] iq);
        logic [2:0] k;
        case (iq)
            2'b00:   k = 3'd1;
            2'b01:   k = 3'd3;
            2'b11:   k = 3'd5;
            default: k = 3'd7;
        endcase
        return k;
    endfunction

    function automatic int midscale(input int w);
        return 32'sd1 <<< (w - 32'sd1);
    endfunction

endpackage

// File: rtl/sine_lut.sv
// Full-wave signed sine ROM with a registered output; table is computed at
// elaboration with peak amplitude 2^(DATA_W-1)-1.
module sine_lut #(
    parameter int LUT_AW = 10,
    parameter int DATA_W = 14
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LUT_AW-1:0]        addr,
    output logic signed [DATA_W-1:0] data
);

    localparam int DEPTH = 2 ** LUT_AW;

    function automatic logic signed [DATA_W-1:0] sine_entry(input int idx);
        real amp;
        real ang;
        amp = real'((2 ** (DATA_W - 1)) - 1);
        ang = 2.0 * 3.14159265358979 * real'(idx) / real'(DEPTH);
        return DATA_W'($rtoi($floor(amp * $sin(ang) + 0.5)));
    endfunction

    logic signed [DATA_W-1:0] rom_s [DEPTH];
    logic signed [DATA_W-1:0] data_q;
    logic signed [DATA_W-1:0] data_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom_s[i] = sine_entry(i);
    end

    // ROM read.
    always_comb begin
        data_d = rom_s[addr];
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/mod_symbol_gen.sv
// Symbol-rate modulator: buffers serial bits, maps them each symbol to a carrier
// phase/amplitude (2ASK, BPSK, QPSK) and streams offset-binary DAC samples.
module mod_symbol_gen
    import mod_pkg::*;
#(
    parameter int DATA_W  = 14,
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 10,
    parameter int SYM_DIV = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic [PHASE_W-1:0] fcw,
    input  logic               bit_in,
    input  logic               bit_valid,
    output logic               bit_ready,
    output logic [DATA_W-1:0]  da_data,
    output logic               da_clk,
    output logic               da_wrt,
    output logic               sym_strobe,
    output logic               underrun
);

    localparam int                CNT_W    = 16;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SYM_DIV - 1);
    localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(midscale(DATA_W));

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         buf_q, buf_d;
    logic [1:0]         occ_q, occ_d;
    mode_e              mode_q, mode_d;
    sym_t               sym_q, sym_d;
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic               under_q, under_d;
    logic               gate_q, gate_d;
    logic [2:0]         strobe_q, strobe_d;
    logic [DATA_W-1:0]  da_q, da_d;

    logic               sym_tick_s;
    logic               push_s;
    logic               pop_s;
    logic [1:0]         nbits_s;
    logic [1:0]         pop_n_s;
    logic [1:0]         rem_s;
    logic [2:0]         k_s;
    logic [LUT_AW-1:0]  lut_addr_s;
    logic signed [DATA_W-1:0] lut_data_s;

    // Symbol timing, bit buffer and symbol register update.
    always_comb begin
        cnt_d    = cnt_q + CNT_W'(1);
        buf_d    = buf_q;
        occ_d    = occ_q;
        mode_d   = mode_q;
        sym_d    = sym_q;
        under_d  = 1'b0;
        pop_n_s  = 2'd0;

        sym_tick_s = (cnt_q == CNT_LAST);
        bit_ready  = (occ_q < 2'd2);
        push_s     = bit_valid && bit_ready;

        if (mode_e'(mode) == MODE_QPSK) begin
            nbits_s = 2'd2;
        end else begin
            nbits_s = 2'd1;
        end
        pop_s = sym_tick_s && (occ_q >= nbits_s);

        if (sym_tick_s) begin
            cnt_d  = '0;
            mode_d = mode_e'(mode);
            if (pop_s) begin
                pop_n_s = nbits_s;
                sym_d   = {1'b0, buf_q[0], (nbits_s == 2'd2) ? buf_q[1] : 1'b0};
            end else begin
                sym_d   = SYM_IDLE;
                under_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Pop shifts survivors to slot 0; an incoming bit lands behind them.
        rem_s = occ_q - pop_n_s;
        if (pop_n_s == 2'd1) begin
            buf_d = {1'b0, buf_q[1]};
        end else if (pop_n_s == 2'd2) begin
            buf_d = 2'b00;
        end else begin
            buf_d = buf_q;
        end
        if (push_s) begin
            buf_d[rem_s[0]] = bit_in;
            occ_d = rem_s + 2'd1;
        end else begin
            occ_d = rem_s;
        end
    end

    // Phase selection, amplitude gate and output formatting.
    always_comb begin
        acc_d    = acc_q + fcw;
        strobe_d = {strobe_q[1:0], sym_tick_s};
        k_s      = 3'd0;
        gate_d   = 1'b0;

        case (mode_q)
            MODE_ASK: begin
                k_s    = 3'd0;
                gate_d = !sym_q.idle && sym_q.b_i;
            end
            MODE_BPSK: begin
                k_s    = sym_q.b_i ? 3'd0 : 3'd4;
                gate_d = !sym_q.idle;
            end
            MODE_QPSK: begin
                k_s    = qpsk_k({sym_q.b_i, sym_q.b_q});
                gate_d = !sym_q.idle;
            end
            default: begin
                k_s    = 3'd0;
                gate_d = 1'b0;
            end
        endcase

        lut_addr_s = LUT_AW'((acc_q + (PHASE_W'(k_s) << (PHASE_W - 3))) >> (PHASE_W - LUT_AW));

        if (gate_q) begin
            da_d = $unsigned(lut_data_s) + MIDSCALE;
        end else begin
            da_d = MIDSCALE;
        end
    end

    sine_lut #(
        .LUT_AW (LUT_AW),
        .DATA_W (DATA_W)
    ) u_lut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (lut_addr_s),
        .data  (lut_data_s)
    );

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            buf_q    <= 2'b00;
            occ_q    <= 2'd0;
            mode_q   <= MODE_ASK;
            sym_q    <= SYM_IDLE;
            acc_q    <= '0;
            under_q  <= 1'b0;
            gate_q   <= 1'b0;
            strobe_q <= 3'b000;
            da_q     <= MIDSCALE;
        end else begin
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            occ_q    <= occ_d;
            mode_q   <= mode_d;
            sym_q    <= sym_d;
            acc_q    <= acc_d;
            under_q  <= under_d;
            gate_q   <= gate_d;
            strobe_q <= strobe_d;
            da_q     <= da_d;
        end
    end

    assign da_data    = da_q;
    assign sym_strobe = strobe_q[2];
    assign underrun   = under_q;
    assign da_clk     = ~clk;
    assign da_wrt     = ~clk;

endmodule

// File: tb/tb_mod_symbol_gen.sv
// Directed bench for mod_symbol_gen with a cycle-indexed reference model of
// symbol scheduling, bit queueing and sine sample generation.
module tb_mod_symbol_gen;

    localparam int          DATA_W  = 14;
    localparam int          PHASE_W = 32;
    localparam int          LUT_AW  = 10;
    localparam int          SYM_DIV = 50;
    localparam logic [31:0] FCW     = 32'd85899346;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic [31:0]       fcw;
    logic              bit_in;
    logic              bit_valid;
    logic              bit_ready;
    logic [DATA_W-1:0] da_data;
    logic              da_clk;
    logic              da_wrt;
    logic              sym_strobe;
    logic              underrun;

    always #10 clk = ~clk;

    mod_symbol_gen #(
        .DATA_W  (DATA_W),
        .PHASE_W (PHASE_W),
        .LUT_AW  (LUT_AW),
        .SYM_DIV (SYM_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .fcw        (fcw),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .bit_ready  (bit_ready),
        .da_data    (da_data),
        .da_clk     (da_clk),
        .da_wrt     (da_wrt),
        .sym_strobe (sym_strobe),
        .underrun   (underrun)
    );

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;

    bit          q[$];
    bit          stim[$];
    logic [31:0] acc_hist [0:1023];
    bit          s_idle   [0:15];
    logic [1:0]  s_mode   [0:15];
    bit          s_b0     [0:15];
    bit          s_b1     [0:15];
    int          keep_a;

    task automatic check(input string name, input int act, input int exp, input int tol);
        vectors++;
        if (act > exp + tol || act < exp - tol) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, n, act, exp);
        end
    endtask

    // Expected DAC code after edge m: state of edge m-2 drives the sample.
    function automatic int exp_da(input int m);
        int          s;
        int          k;
        int          addr;
        logic [31:0] p;
        real         v;
        if (m < 2) return 8192;
        s = (m - 2) / SYM_DIV;
        if (s_idle[s] || s_mode[s] == 2'b11 || (s_mode[s] == 2'b00 && !s_b0[s])) return 8192;
        k = 0;
        if (s_mode[s] == 2'b01) begin
            k = s_b0[s] ? 0 : 4;
        end else if (s_mode[s] == 2'b10) begin
            if (!s_b0[s] && !s_b1[s])     k = 1;
            else if (!s_b0[s] && s_b1[s]) k = 3;
            else if (s_b0[s] && s_b1[s])  k = 5;
            else                          k = 7;
        end
        p    = acc_hist[m-2] + (32'(k) << 29);
        addr = int'(p >> 22);
        v    = 8191.0 * $sin(2.0 * 3.14159265358979 * real'(addr) / 1024.0);
        return 8192 + $rtoi($floor(v + 0.5));
    endfunction

    task automatic do_reset(input logic [1:0] md);
        @(negedge clk);
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        mode      = md;
        fcw       = FCW;
        n         = 0;
        q.delete();
        stim.delete();
        for (int i = 0; i < 16; i++) begin
            s_idle[i] = 1'b1;
            s_mode[i] = 2'b00;
            s_b0[i]   = 1'b0;
            s_b1[i]   = 1'b0;
        end
        acc_hist[0] = 32'd0;
        repeat (3) begin
            @(negedge clk);
            check("rst_da_data", da_data, 8192, 0);
            check("rst_bit_ready", bit_ready, 1, 0);
            check("rst_sym_strobe", sym_strobe, 0, 0);
            check("rst_underrun", underrun, 0, 0);
        end
        rst_n = 1'b1;
    endtask

    // One clock: drive, advance the model at the edge, compare at the next negedge.
    task automatic step();
        bit rdy;
        bit xfer;
        int nb;
        int s;
        bit_valid = (stim.size() > 0);
        bit_in    = bit_valid ? stim[0] : 1'b0;
        rdy       = (q.size() < 2);
        check("bit_ready", bit_ready, rdy, 0);
        xfer = bit_valid && rdy;
        @(posedge clk);
        n++;
        acc_hist[n] = 32'(n) * FCW;
        if (n % SYM_DIV == 0) begin
            s         = n / SYM_DIV;
            s_mode[s] = mode;
            nb        = (mode == 2'b10) ? 2 : 1;
            if (q.size() >= nb) begin
                s_idle[s] = 1'b0;
                s_b0[s]   = q.pop_front();
                s_b1[s]   = (nb == 2) ? q.pop_front() : 1'b0;
            end else begin
                s_idle[s] = 1'b1;
            end
        end
        if (xfer) begin
            q.push_back(bit_in);
            void'(stim.pop_front());
        end
        @(negedge clk);
        check("da_data", da_data, exp_da(n), 1);
        check("sym_strobe", sym_strobe, int'(n >= 52 && (n - 2) % SYM_DIV == 0), 0);
        check("underrun", underrun, int'(n >= 50 && n % SYM_DIV == 0 && s_idle[n / SYM_DIV]), 0);
        check("da_clk", da_clk, 1, 0);
        check("da_wrt", da_wrt, 1, 0);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 2'b00;
        fcw       = FCW;
        bit_in    = 1'b0;
        bit_valid = 1'b0;

        // Idle: no bits, underrun every symbol.
        do_reset(2'b00);
        run(49);
        check("idle_no_early_underrun", underrun, 0, 0);
        run(1);
        check("idle_first_underrun", underrun, 1, 0);
        run(110);

        // 2ASK 1,0,1.
        do_reset(2'b00);
        stim = '{1'b1, 1'b0, 1'b1};
        run(52);
        check("ask_strobe_at_52", sym_strobe, 1, 0);
        run(12);
        check("ask_peak_pin", da_data, 16364, 1);
        keep_a = int'(da_data);
        run(46);
        check("ask_zero_symbol", da_data, 8192, 0);
        run(150);

        // BPSK 1 then 0: second symbol mirrors the first about midscale.
        do_reset(2'b01);
        stim = '{1'b1, 1'b0};
        run(64);
        check("bpsk_bit1_pin", da_data, 16364, 1);
        keep_a = int'(da_data);
        run(50);
        check("bpsk_bit0_pin", da_data, 20, 1);
        check("bpsk_mirror_sum", keep_a + int'(da_data), 16384, 2);
        run(46);

        // QPSK 0,0,1,1.
        do_reset(2'b10);
        stim = '{1'b0, 1'b0, 1'b1, 1'b1};
        run(2);
        check("qpsk_full_not_ready", bit_ready, 0, 0);
        run(62);
        check("qpsk_k1_pin", da_data, 14361, 1);
        run(96);

        // QPSK: bit arrives on the symbol tick with one bit buffered.
        do_reset(2'b10);
        stim = '{1'b0};
        run(49);
        stim.push_back(1'b1);
        run(1);
        check("tick_xfer_underrun", underrun, 1, 0);
        check("tick_xfer_full", bit_ready, 0, 0);
        run(110);

        // Mode change BPSK->QPSK mid-symbol.
        do_reset(2'b01);
        stim = '{1'b1, 1'b0, 1'b1};
        run(70);
        mode = 2'b10;
        run(32);
        check("mode_hold_bpsk", da_data, exp_da(n), 1);
        run(58);

        // Reset mid-symbol discards the buffer.
        do_reset(2'b01);
        stim = '{1'b0, 1'b1};
        run(25);
        do_reset(2'b01);
        run(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mod_symbol_gen.md
MOD_SYMBOL_GEN -- requirements
Module: mod_symbol_gen

Interface
REQ-001 Parameter DATA_W, default 14: DAC sample width in bits.
REQ-002 Parameter PHASE_W, default 32: phase accumulator width in bits.
REQ-003 Parameter LUT_AW, default 10: sine LUT address width in bits.
REQ-004 Parameter SYM_DIV, default 50: clock cycles per symbol; legal range 4..65535.
REQ-005 Port clk, input, 1: single system clock (50 MHz nominal).
REQ-006 Port rst_n, input, 1: reset; asynchronous, active-low.
REQ-007 Port mode, input, 2: modulation select; 00=2ASK, 01=BPSK, 10=QPSK, 11=reserved.
REQ-008 Port fcw, input, PHASE_W: carrier frequency control word.
REQ-009 Port bit_in, input, 1: serial payload bit.
REQ-010 Port bit_valid, input, 1: bit_in is valid.
REQ-011 Port bit_ready, output, 1: bit buffer can accept a bit.
REQ-012 Port da_data, output, DATA_W: offset-binary DAC sample.
REQ-013 Port da_clk, output, 1: DAC clock; equals inverted clk.
REQ-014 Port da_wrt, output, 1: DAC write strobe; equals inverted clk.
REQ-015 Port sym_strobe, output, 1: one-cycle pulse when a symbol boundary occurs.
REQ-016 Port underrun, output, 1: one-cycle pulse when a symbol starts with insufficient bits.

Function
REQ-017 Symbol counter SHALL count 0..SYM_DIV-1 and wrap; sym_tick is asserted when the count equals SYM_DIV-1.
REQ-018 Bit buffer: 2 entries, FIFO order; bit_ready = (occupancy < 2); a bit transfers when bit_valid && bit_ready.
REQ-019 Bits per symbol N: 1 for 2ASK, BPSK and reserved; 2 for QPSK.
REQ-020 mode SHALL be sampled only on sym_tick; mid-symbol changes SHALL have no effect until the next boundary.
REQ-021 On sym_tick with occupancy >= N: pop N bits into the symbol register; the first popped bit is the MSB (I).
REQ-022 On sym_tick with occupancy < N: pop nothing, load the IDLE symbol, and pulse underrun.
REQ-023 A transfer and a pop in the same cycle SHALL both take effect; occupancy becomes old - popped + 1. The incoming bit queues behind existing bits and is never used by the symbol starting in that cycle.
REQ-024 Phase accumulator: acc <= acc + fcw every cycle, modulo 2^PHASE_W.
REQ-025 LUT address = top LUT_AW bits of (acc + offset), where offset is k * 2^(PHASE_W-3) (units of 45 degrees).
- BPSK: bit 1 -> k=0; bit 0 -> k=4.
- QPSK (Gray): 00 -> k=1; 01 -> k=3; 11 -> k=5; 10 -> k=7.
- 2ASK: k=0.
REQ-026 Amplitude gate: the sample SHALL be forced to 0 for 2ASK bit 0, reserved mode, and IDLE; otherwise the LUT sample passes unmodified.
REQ-027 da_data = signed sample + 2^(DATA_W-1); zero maps to 8192 for DATA_W=14.
REQ-028 Latency: a new symbol SHALL appear on da_data exactly 3 cycles after its sym_tick (symbol register -> LUT register -> output register).
REQ-029 sym_strobe SHALL be registered and coincide with the first da_data sample of the new symbol.

Reset
REQ-030 While rst_n=0, all of the following SHALL hold:
- symbol counter = 0, acc = 0, bit buffer empty;
- symbol register = IDLE, registered mode = 00;
- da_data = 2^(DATA_W-1);
- sym_strobe = 0, underrun = 0.
REQ-031 bit_ready SHALL read 1 during and immediately after reset (buffer empty).
REQ-032 Reset asserted mid-symbol SHALL discard buffered bits. The first sym_tick occurs SYM_DIV cycles after rst_n rises.

Structure
REQ-033 Shared package mod_pkg SHALL hold:
- mode encodings, the IDLE symbol encoding, and the QPSK Gray-to-k table;
- the midscale constant function of DATA_W.
REQ-034 Sub-module sine_lut: parameters LUT_AW and DATA_W; one-cycle registered signed full-wave output; contents generated at elaboration.

Verification
REQ-035 Scenarios, with SYM_DIV=50, fcw=85899346 (1 MHz carrier), DATA_W=14 unless stated:
- Reset, then no bits -> da_data holds 8192; underrun pulses every 50 cycles, first pulse 50 cycles after rst_n rises.
- 2ASK, stream 1,0,1 -> carrier for 50 cycles, then 8192 for 50 cycles, then carrier; each transition lands 3 cycles after its sym_tick.
- BPSK, bits 1 then 0 -> the second symbol's samples equal the first symbol's samples negated about 8192 (within +/-1 LSB) at equal acc.
- QPSK, bits 0,0,1,1 -> symbols k=1 then k=5; bit_ready drops to 0 with 2 bits buffered.
- Bit transfer on the sym_tick cycle with occupancy 1 in QPSK -> underrun pulse; occupancy becomes 2; next symbol uses both bits.
- Mode changed 01->10 at counter=20 -> output stays BPSK until the next sym_tick + 3.
